// File: rtl/approx_err_monitor_if.sv
// Command/result bundle of the approximate-adder error monitor.
// The host side drives the run request; the engine returns status and results.
interface approx_err_monitor_if #(
    parameter int N         = 16,
    parameter int SAMPLES_W = 24
);
    logic                   start;
    logic [SAMPLES_W-1:0]   num_samples;
    logic [31:0]            seed;
    logic                   busy;
    logic                   done;
    logic [SAMPLES_W-1:0]   err_count;
    logic [SAMPLES_W+N-1:0] sum_ed;
    logic [N-1:0]           max_ed;

    modport master (
        output start, num_samples, seed,
        input  busy, done, err_count, sum_ed, max_ed
    );

    modport slave (
        input  start, num_samples, seed,
        output busy, done, err_count, sum_ed, max_ed
    );
endinterface

// File: rtl/approx_err_monitor.sv
// Self-sequenced error characterisation of an OLOCA approximate adder:
// LFSR operands, exact reference, 3-stage ED/ER accumulation pipeline.
module approx_err_monitor #(
    parameter int N         = 16,
    parameter int K         = 6,
    parameter int SAMPLES_W = 24,
    parameter int EXACT     = 0
) (
    input  logic                clk,
    input  logic                rst,
    approx_err_monitor_if.slave bus
);
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          KC   = K / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [31:0]          lfsr;
    logic [31:0]          lfsr_nxt;
    logic [SAMPLES_W-1:0] cnt;
    logic                 drain;

    logic                 s1_v;
    logic [N-1:0]         s1_x;
    logic [N-1:0]         s1_y;
    logic                 s2_v;
    logic [N-1:0]         s2_ed;
    logic                 s2_mism;

    logic [N-1:0]         s_apx;
    logic [N-1:0]         s_ext;
    logic [N-1:0]         ed_c;

    // OLOCA: lowest K/2 bits forced to 1, rest of the lower part OR'd,
    // upper part added exactly with no carry from the lower part.
    function automatic logic [N-1:0] oloca(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
        logic [N-1:0] ha;
        logic [N-1:0] hb;
        logic [N-1:0] r;
        ha = a >> K;
        hb = b >> K;
        r  = (ha + hb) << K;
        for (int i = 0; i < N; i++) begin
            if (i < KC)
                r[i] = 1'b1;
            else if (i < K)
                r[i] = a[i] | b[i];
        end
        return r;
    endfunction

    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

    always_comb begin
        s_ext = s1_x + s1_y;
        if (EXACT != 0)
            s_apx = s1_x + s1_y;
        else
            s_apx = oloca(s1_x, s1_y);
        if (s_apx >= s_ext)
            ed_c = s_apx - s_ext;
        else
            ed_c = s_ext - s_apx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_ed   <= '0;
            s2_mism <= 1'b0;
        end else begin
            s2_v    <= s1_v;
            s2_ed   <= ed_c;
            s2_mism <= (ed_c != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= 32'h1;
            cnt           <= '0;
            drain         <= 1'b0;
            s1_v          <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err_count <= '0;
            bus.sum_ed    <= '0;
            bus.max_ed    <= '0;
        end else begin
            s1_v <= 1'b0;
            if (s2_v) begin
                bus.err_count <= bus.err_count
                               + SAMPLES_W'(s2_mism);
                bus.sum_ed    <= bus.sum_ed
                               + (SAMPLES_W+N)'(s2_ed);
                if (s2_ed > bus.max_ed)
                    bus.max_ed <= s2_ed;
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.err_count <= '0;
                        bus.sum_ed    <= '0;
                        bus.max_ed    <= '0;
                        lfsr <= (bus.seed == 32'h0)
                              ? 32'h1 : bus.seed;
                        cnt  <= bus.num_samples;
                        if (bus.num_samples == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    lfsr <= lfsr_nxt;
                    s1_x <= lfsr_nxt[N-1:0];
                    s1_y <= lfsr_nxt[31:32-N];
                    s1_v <= 1'b1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SAMPLES_W'(1)) begin
                        state <= DRAIN;
                        drain <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        drain <= 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
